ex_sequencer: RTL

Multi-cycle execute-stage sequencer that wraps the ALU operation set and adds an iterative shift-add multiplier. It accepts one operation at a time over a valid/ready handshake. Add, sub, and, or and nop complete in one cycle; mul takes WIDTH+1 cycles. While a multiply is in flight it drives a stall to the pipeline hazard logic.

---
 rtl/ex_sequencer.sv | 80 ++++++++
 1 files changed

// File: rtl/ex_sequencer.sv
// ex_sequencer: single-cycle ALU ops plus an iterative shift-add multiplier behind a valid/ready handshake
module ex_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] result_o,
    output logic             done_o,
    output logic             stall_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] acc, mcand, mplier, alu, sum;
    logic [CW-1:0]    cnt;
    logic             accept, is_mul, last;

    always_comb begin
        ready_o = state == IDLE;
        stall_o = state == MUL;
        is_mul  = ALUCtrl_i == 3'b111;
        accept  = valid_i & ready_o & ~flush_i;
        last    = stall_o & (cnt == LAST);
        sum     = acc + (mplier[0] ? mcand : '0);
        alu     = ALUCtrl_i == 3'b010 ? data1_i + data2_i :
                  ALUCtrl_i == 3'b110 ? data1_i - data2_i :
                  ALUCtrl_i == 3'b000 ? data1_i & data2_i :
                  ALUCtrl_i == 3'b001 ? data1_i | data2_i : '0;
        state_n = state;
        if (state == IDLE && accept && is_mul)
            state_n = MUL;
        else if (state == MUL && (flush_i || last))
            state_n = IDLE;
    end

    always_ff @(posedge clk_i)
        state <= rst_i ? IDLE : state_n;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            result_o <= '0;
            done_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (state == IDLE) begin
                if (accept && is_mul) begin
                    acc    <= '0;
                    mcand  <= data1_i;
                    mplier <= data2_i;
                    cnt    <= '0;
                end else if (accept) begin
                    result_o <= alu;
                    done_o   <= 1'b1;
                end
            end else if (!flush_i) begin
                acc    <= sum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (last) begin
                    result_o <= sum;
                    done_o   <= 1'b1;
                end
            end
        end
    end
endmodule
